// File: rtl/clb_lut_if.sv
// clb_lut_if -- bus bundle for the configurable LUT cell.
// Carries the LUT select, output-register enable, the serial configuration
// port and the status pulses. K must match the K of the attached clb_lut.
interface clb_lut_if #(
   parameter int K = 4
);
   logic [K-1:0] in;        // LUT select, in[0] is the fastest truth-table input
   logic         ce;        // clock enable of the optional output register
   logic         cfg_en;    // shift one configuration bit this cycle
   logic         cfg_din;   // serial configuration data
   logic         cfg_load;  // commit the shifted frame
   logic         cfg_dout;  // serial chain output for daisy-chaining
   logic         out;       // LUT output
   logic         cfg_done;  // one-cycle pulse: commit accepted
   logic         cfg_err;   // one-cycle pulse: commit rejected

   // Driver side (configuration controller / user logic)
   modport master (
      output in, ce, cfg_en, cfg_din, cfg_load,
      input  cfg_dout, out, cfg_done, cfg_err
   );

   // LUT cell side
   modport slave (
      input  in, ce, cfg_en, cfg_din, cfg_load,
      output cfg_dout, out, cfg_done, cfg_err
   );
endinterface

// File: rtl/clb_lut.sv
// clb_lut -- K-input look-up table with a serially loaded configuration frame.
// Frame of 2**K+1 bits: mask bits first (index 0 first), mode bit last.
// A frame is committed only when exactly one full frame was shifted since the
// previous load or reset; otherwise the load is rejected and the active
// configuration is kept.
// Optional feature macro LUT_FF_EN: builds the clock-enabled output register
// and the mode-selected output. Without it the output is purely
// combinational and the stored mode bit / ce input have no effect.
module clb_lut #(
   parameter int K = 4
) (
   input  logic     clk,
   input  logic     rst,
   clb_lut_if.slave bus
);

   localparam int MW      = 2 ** K;
   localparam int CFG_LEN = MW + 1;
   // counter must hold CFG_LEN+1 (saturation value)
   localparam int CW      = $clog2(CFG_LEN + 2);

   localparam logic [CW-1:0] CNT_FULL = CW'(CFG_LEN);
   localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_LEN + 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CFG_LEN-1:0]  sr_q,    sr_d;
   logic [CW-1:0]       cnt_q,   cnt_d;
   logic [MW-1:0]       mask_q,  mask_d;
   logic                mode_q,  mode_d;
   logic                done_q,  done_d;
   logic                err_q,   err_d;
   logic                commit;
   logic                comb;

   // Configuration FSM: next state, shift register, bit counter and commit decision
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      mode_d  = mode_q;
      commit  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE:  if (bus.cfg_en) state_d = ST_SHIFT;
         ST_SHIFT: state_d = ST_SHIFT;
         default:  state_d = ST_IDLE;
      endcase

      if (bus.cfg_load) begin
         // A load always terminates the frame; a simultaneous shift is dropped.
         state_d = ST_IDLE;
         cnt_d   = '0;
         if (!bus.cfg_en && state_q == ST_SHIFT && cnt_q == CNT_FULL) begin
            commit = 1'b1;
         end
         done_d = commit;
         err_d  = !commit;
         if (commit) begin
            mask_d = sr_q[MW-1:0];
            mode_d = sr_q[MW];
         end
      end else if (bus.cfg_en) begin
         sr_d = {bus.cfg_din, sr_q[CFG_LEN-1:1]};
         if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Configuration state registers; reset discards any partial frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Truth-table lookup: zero-latency path from the select inputs
   always_comb begin
      comb = mask_q[bus.in];
   end

`ifdef LUT_FF_EN
   logic ff_q, ff_d;

   // Output register next value: capture the lookup only when enabled
   always_comb begin
      ff_d = ff_q;
      if (bus.ce) begin
         ff_d = comb;
      end
   end

   // Output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff_q <= 1'b0;
      end else begin
         ff_q <= ff_d;
      end
   end

   assign bus.out = mode_q ? ff_q : comb;
`else
   // Mode bit is still part of the frame but has no effect; ce is not needed.
   logic unused_cfg;
   assign unused_cfg = ^{bus.ce, mode_q};

   assign bus.out = comb;
`endif

   assign bus.cfg_dout = sr_q[0];
   assign bus.cfg_done = done_q;
   assign bus.cfg_err  = err_q;

endmodule
